// File: rtl/alu_slice_serial.sv
// alu_slice_serial: N-bit ALU (AND/OR/ADD/SUB) evaluated SLICE bits per clock.
// The carry is kept in a register between slices, so one narrow adder serves
// the full operand width. A start/busy/done handshake frames each operation,
// and the cout/zero/overflow flags are updated only when the last slice lands.
module alu_slice_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         op_q;

  logic               accept;
  logic               last;
  logic [SLICE-1:0]   a_s;
  logic [SLICE-1:0]   b_raw;
  logic [SLICE-1:0]   b_s;
  logic [SLICE-1:0]   s_bits;
  logic               s_c;
  logic               s_cm;
  logic [WIDTH-1:0]   res_nxt;

  // One slice of ripple addition. Returns {carry out, carry into the slice
  // MSB, sum}; the carry into the MSB is recovered from the sum bit so that
  // signed overflow can be formed on the final slice.
  function automatic logic [SLICE+1:0] slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             ci
  );
    logic [SLICE:0] s;
    s = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
    return {s[SLICE], x[SLICE-1] ^ y[SLICE-1] ^ s[SLICE-1], s[SLICE-1:0]};
  endfunction

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CNT_W'(N - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Slice datapath: select the active slice, apply the operation and merge
  // the new bits into a copy of the result register.
  always_comb begin
    a_s     = a_q[int'(cnt)*SLICE +: SLICE];
    b_raw   = b_q[int'(cnt)*SLICE +: SLICE];
    b_s     = (op_q == OP_SUB) ? ~b_raw : b_raw;
    s_bits  = '0;
    s_c     = 1'b0;
    s_cm    = 1'b0;
    case (op_q)
      OP_AND:  s_bits = a_s & b_s;
      OP_OR:   s_bits = a_s | b_s;
      default: {s_c, s_cm, s_bits} = slice_add(a_s, b_s, carry);
    endcase
    res_nxt = result;
    res_nxt[int'(cnt)*SLICE +: SLICE] = s_bits;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: one RUN cycle per slice, then a single DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on acceptance; operands carry no reset as they are only
  // read while RUN, which is always preceded by a capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Control, carry chain, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_AND;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      cnt  <= '0;
      case (op)
        OP_ADD:  carry <= cin;
        OP_SUB:  carry <= 1'b1;
        default: carry <= 1'b0;
      endcase
    end else if (state == RUN) begin
      result <= res_nxt;
      carry  <= s_c;
      cnt    <= last ? '0 : cnt + CNT_W'(1);
      if (last) begin
        cout     <= s_c;
        overflow <= s_c ^ s_cm;
        zero     <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_slice_serial.sv
// Bench for alu_slice_serial: three instances (SLICE = 1, 2, 8 at WIDTH = 8)
// share one stimulus stream and are checked against a full-width model.
module tb_alu_slice_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [1:0] op;

  logic       busy1, done1, cout1, zero1, ovf1;
  logic       busy2, done2, cout2, zero2, ovf2;
  logic       busy8, done8, cout8, zero8, ovf8;
  logic [7:0] res1, res2, res8;

  logic       busy_v [3];
  logic       done_v [3];
  logic       cout_v [3];
  logic       zero_v [3];
  logic       ovf_v  [3];
  logic [7:0] res_v  [3];

  localparam int NEXP [3] = '{8, 4, 1};
  localparam int SLC  [3] = '{1, 2, 8};

  int ncmp;
  int nfail;

  alu_slice_serial #(.WIDTH(8), .SLICE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .op(op),
    .busy(busy1), .done(done1), .result(res1), .cout(cout1), .zero(zero1), .overflow(ovf1));
  alu_slice_serial #(.WIDTH(8), .SLICE(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .op(op),
    .busy(busy2), .done(done2), .result(res2), .cout(cout2), .zero(zero2), .overflow(ovf2));
  alu_slice_serial #(.WIDTH(8), .SLICE(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .op(op),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .zero(zero8), .overflow(ovf8));

  assign busy_v[0] = busy1;  assign busy_v[1] = busy2;  assign busy_v[2] = busy8;
  assign done_v[0] = done1;  assign done_v[1] = done2;  assign done_v[2] = done8;
  assign cout_v[0] = cout1;  assign cout_v[1] = cout2;  assign cout_v[2] = cout8;
  assign zero_v[0] = zero1;  assign zero_v[1] = zero2;  assign zero_v[2] = zero8;
  assign ovf_v[0]  = ovf1;   assign ovf_v[1]  = ovf2;   assign ovf_v[2]  = ovf8;
  assign res_v[0]  = res1;   assign res_v[1]  = res2;   assign res_v[2]  = res8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-width reference: returns {overflow, zero, cout, result}.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] o, input logic c);
    logic [8:0] s;
    logic [7:0] r;
    logic       co;
    logic       ov;
    co = 1'b0;
    ov = 1'b0;
    case (o)
      2'b00: r = x & y;
      2'b01: r = x | y;
      2'b10: begin
        s  = {1'b0, x} + {1'b0, y} + {8'b0, c};
        r  = s[7:0];
        co = s[8];
        ov = (x[7] == y[7]) && (r[7] != x[7]);
      end
      default: begin
        r  = x - y;
        co = (x >= y);
        ov = (x[7] != y[7]) && (r[7] != x[7]);
      end
    endcase
    return {ov, (r == 8'h00), co, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op, scramble the inputs and poke start while it runs, then
  // check latency, pulse width, busy length and the held result/flags.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] o, input logic c);
    int          lat  [3];
    int          dcnt [3];
    int          bcnt [3];
    logic [10:0] m;
    m = model(x, y, o, c);
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; dcnt[i] = 0; bcnt[i] = 0;
    end
    a = x; b = y; op = o; cin = c; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) if (busy_v[i]) bcnt[i]++;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          dcnt[i]++;
          if (lat[i] == 0) lat[i] = k;
        end
        if (busy_v[i]) bcnt[i]++;
      end
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); cin = 1'($urandom);
      start = (k < 2);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat_s%0d", SLC[i]), lat[i], NEXP[i]);
      check($sformatf("done_width_s%0d", SLC[i]), dcnt[i], 1);
      check($sformatf("busy_len_s%0d", SLC[i]), bcnt[i], NEXP[i]);
      check($sformatf("result_s%0d op%0d %0h,%0h", SLC[i], o, x, y), {24'b0, res_v[i]}, {24'b0, m[7:0]});
      check($sformatf("cout_s%0d op%0d %0h,%0h", SLC[i], o, x, y), {31'b0, cout_v[i]}, {31'b0, m[8]});
      check($sformatf("zero_s%0d op%0d %0h,%0h", SLC[i], o, x, y), {31'b0, zero_v[i]}, {31'b0, m[9]});
      check($sformatf("ovf_s%0d op%0d %0h,%0h", SLC[i], o, x, y), {31'b0, ovf_v[i]}, {31'b0, m[10]});
    end
  endtask

  task automatic expect2(input string tag, input logic [7:0] r, input logic c,
                         input logic z, input logic v);
    check({tag, "_res"}, {24'b0, res2}, {24'b0, r});
    check({tag, "_cout"}, {31'b0, cout2}, {31'b0, c});
    check({tag, "_zero"}, {31'b0, zero2}, {31'b0, z});
    check({tag, "_ovf"}, {31'b0, ovf2}, {31'b0, v});
  endtask

  task automatic check_all_clear(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_busy_s%0d", tag, SLC[i]), {31'b0, busy_v[i]}, 32'd0);
      check($sformatf("%s_done_s%0d", tag, SLC[i]), {31'b0, done_v[i]}, 32'd0);
      check($sformatf("%s_res_s%0d", tag, SLC[i]), {24'b0, res_v[i]}, 32'd0);
      check($sformatf("%s_cout_s%0d", tag, SLC[i]), {31'b0, cout_v[i]}, 32'd0);
      check($sformatf("%s_zero_s%0d", tag, SLC[i]), {31'b0, zero_v[i]}, 32'd0);
      check($sformatf("%s_ovf_s%0d", tag, SLC[i]), {31'b0, ovf_v[i]}, 32'd0);
    end
  endtask

  initial begin
    int d_first;
    int d_second;
    int dn;
    ncmp  = 0;
    nfail = 0;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; op = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_clear("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(8'h7F, 8'h00, 2'b10, 1'b1); expect2("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 2'b11, 1'b0); expect2("sub_ovf", 8'h7F, 1'b1, 1'b0, 1'b1);
    run_op(8'h05, 8'h07, 2'b11, 1'b1); expect2("sub_borrow", 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op(8'hF0, 8'h3C, 2'b00, 1'b1); expect2("and", 8'h30, 1'b0, 1'b0, 1'b0);
    run_op(8'hF0, 8'h3C, 2'b01, 1'b1); expect2("or", 8'hFC, 1'b0, 1'b0, 1'b0);
    run_op(8'h0F, 8'hF0, 2'b00, 1'b0); expect2("and_zero", 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 2'b10, 1'b0); expect2("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of RUN (SLICE=2 instance at slice 2)
    a = 8'hFF; b = 8'h00; op = 2'b01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_busy_before", {31'b0, busy2}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_clear("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done2) dn++;
    end
    check("midrun_no_done", dn, 0);
    run_op(8'h3A, 8'h5C, 2'b10, 1'b1); expect2("after_rst", 8'h97, 1'b0, 1'b0, 1'b1);

    // Start held high: consecutive done pulses N+2 cycles apart
    a = 8'h12; b = 8'h34; op = 2'b10; cin = 1'b0; start = 1'b1;
    d_first = 0; d_second = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done2 && d_first == 0) d_first = k;
      else if (done2 && d_second == 0) d_second = k;
    end
    start = 1'b0;
    check("held_start_first_seen", {31'b0, (d_first != 0)}, 32'd1);
    check("held_start_spacing", d_second - d_first, 6);
    repeat (12) @(posedge clk);
    #1;

    // Randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
